// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - execute-stage sequencer around the combinational ALU
module alu_exec_ctrl #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_cond,
  input  logic [4:0]        in_op,
  input  logic              in_s,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  output logic [4:0]        alu_op,
  output logic [DATA_W-1:0] alu_data1,
  output logic [DATA_W-1:0] alu_data2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        cpsr,
  output logic              retire,
  output logic              retire_exec,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;

  state_t             cur, nxt;
  logic [3:0]         cond_r;
  logic               s_r;
  logic [REG_W-1:0]   rd_r;
  logic               pass;
  logic               op_wb;
  logic               op_cmp;

  // Ops that produce a register result: AND EOR SUB RSB ADD ORR MOV BIC MVN.
  function automatic logic is_wb_op(input logic [4:0] op);
    case (op)
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
      5'b01100, 5'b01101, 5'b01110, 5'b01111: is_wb_op = 1'b1;
      default:                                is_wb_op = 1'b0;
    endcase
  endfunction

  // ARM condition check; flag vector is {V,N,C,Z}.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic z, cy, n, v;
    z  = f[0];
    cy = f[1];
    n  = f[2];
    v  = f[3];
    case (c)
      4'h0: cond_pass = z;
      4'h1: cond_pass = !z;
      4'h2: cond_pass = cy;
      4'h3: cond_pass = !cy;
      4'h4: cond_pass = n;
      4'h5: cond_pass = !n;
      4'h6: cond_pass = v;
      4'h7: cond_pass = !v;
      4'h8: cond_pass = cy && !z;
      4'h9: cond_pass = !cy || z;
      4'ha: cond_pass = (n == v);
      4'hb: cond_pass = (n != v);
      4'hc: cond_pass = !z && (n == v);
      4'hd: cond_pass = z || (n != v);
      4'he: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // cpsr only changes at the end of EXEC, so this is the value at EXEC entry.
  assign pass   = cond_pass(cond_r, cpsr);
  assign op_wb  = is_wb_op(alu_op);
  assign op_cmp = (alu_op[4:2] == 3'b010);
  assign state  = cur;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= IDLE;
    else       cur <= nxt;
  end

  // Next-state: EXEC lasts one cycle, WB waits for the register file.
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    if (in_valid) nxt = EXEC;
      EXEC:    nxt = (pass && op_wb) ? WB : IDLE;
      WB:      if (wb_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state so reset drops wb_valid at once.
  always_comb begin
    in_ready = (cur == IDLE);
    wb_valid = (cur == WB);
  end

  // Instruction latch, flag update, writeback capture and retire pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cond_r      <= '0;
      s_r         <= 1'b0;
      rd_r        <= '0;
      alu_op      <= '0;
      alu_data1   <= '0;
      alu_data2   <= '0;
      wb_rd       <= '0;
      wb_data     <= '0;
      cpsr        <= '0;
      retire      <= 1'b0;
      retire_exec <= 1'b0;
    end else begin
      retire      <= 1'b0;
      retire_exec <= 1'b0;
      case (cur)
        IDLE: begin
          if (in_valid) begin
            cond_r    <= in_cond;
            s_r       <= in_s;
            rd_r      <= in_rd;
            alu_op    <= in_op;
            alu_data1 <= in_data1;
            alu_data2 <= in_data2;
          end
        end
        EXEC: begin
          if (pass) begin
            if (op_cmp || (s_r && op_wb)) cpsr <= alu_flags;
            if (op_wb) begin
              wb_data <= alu_result;
              wb_rd   <= rd_r;
            end else begin
              retire      <= 1'b1;
              retire_exec <= 1'b1;
            end
          end else begin
            retire <= 1'b1;
          end
        end
        WB: begin
          if (wb_ready) begin
            retire      <= 1'b1;
            retire_exec <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb/tb_alu_exec_ctrl.sv - self-checking bench for alu_exec_ctrl
module tb_alu_exec_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_cond = '0;
  logic [4:0]  in_op = '0;
  logic        in_s = 1'b0;
  logic [3:0]  in_rd = '0;
  logic [31:0] in_data1 = '0;
  logic [31:0] in_data2 = '0;
  logic [4:0]  alu_op;
  logic [31:0] alu_data1, alu_data2, alu_result;
  logic [3:0]  alu_flags;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  cpsr;
  logic        retire, retire_exec;
  logic [1:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.DATA_W(32), .REG_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_cond(in_cond), .in_op(in_op), .in_s(in_s), .in_rd(in_rd),
    .in_data1(in_data1), .in_data2(in_data2), .alu_op(alu_op),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_result(alu_result),
    .alu_flags(alu_flags), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .cpsr(cpsr), .retire(retire),
    .retire_exec(retire_exec), .state(state)
  );

  // Reference ALU: returns {V,N,C,Z, result}.
  function automatic logic [35:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; r = '0;
    case (op)
      5'b00000, 5'b01000: r = a & b;
      5'b00001, 5'b01001: r = a ^ b;
      5'b00010, 5'b01010: begin r = a - b; c = (a >= b); v = (a[31] != b[31]) && (r[31] != a[31]); end
      5'b00011:           begin r = b - a; c = (b >= a); v = (a[31] != b[31]) && (r[31] != b[31]); end
      5'b00100, 5'b01011: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
      5'b01100: r = a | b;
      5'b01101: r = b;
      5'b01110: r = a & ~b;
      5'b01111: r = ~b;
      default:  r = '0;
    endcase
    alu_fn = {v, r[31], c, (r == 32'd0), r};
  endfunction

  assign {alu_flags, alu_result} = alu_fn(alu_op, alu_data1, alu_data2);

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit z, cy, n, v;
    {v, n, cy, z} = f;
    case (c)
      0: return z;          1: return !z;
      2: return cy;         3: return !cy;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return cy && !z;   9: return !cy || z;
      10: return n == v;    11: return n != v;
      12: return !z && n == v;
      13: return z || n != v;
      14: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic bit wb_class(input logic [4:0] op);
    return (op <= 5'd4) || (op >= 5'd12 && op <= 5'd15);
  endfunction

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: outcome decided at accept, then replayed in time.
  bit         m_exec, m_wbpend, m_ret, m_rexec;
  logic [3:0] m_cpsr, m_wb_rd;
  logic [31:0] m_wb_data, m_d1, m_d2;
  logic [4:0] m_op;
  bit         p_pass, p_upd, p_wb;
  logic [3:0] p_flags, p_rd;
  logic [31:0] p_res;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_exec = 0; m_wbpend = 0; m_ret = 0; m_rexec = 0;
      m_cpsr = '0; m_wb_rd = '0; m_wb_data = '0; m_d1 = '0; m_d2 = '0; m_op = '0;
    end else begin
      m_ret = 0; m_rexec = 0;
      if (m_wbpend) begin
        if (wb_ready) begin m_wbpend = 0; m_ret = 1; m_rexec = 1; end
      end else if (m_exec) begin
        m_exec = 0;
        if (p_pass) begin
          if (p_upd) m_cpsr = p_flags;
          if (p_wb) begin m_wbpend = 1; m_wb_data = p_res; m_wb_rd = p_rd; end
          else begin m_ret = 1; m_rexec = 1; end
        end else m_ret = 1;
      end else if (in_valid) begin
        {p_flags, p_res} = alu_fn(in_op, in_data1, in_data2);
        p_pass = cond_ok(in_cond, m_cpsr);
        p_wb   = wb_class(in_op);
        p_upd  = (in_op >= 5'd8 && in_op <= 5'd11) || (in_s && p_wb);
        p_rd   = in_rd;
        m_op = in_op; m_d1 = in_data1; m_d2 = in_data2;
        m_exec = 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready", in_ready, !(m_exec || m_wbpend));
      chk("wb_valid", wb_valid, m_wbpend);
      chk("state", state, m_exec ? 2'd1 : (m_wbpend ? 2'd2 : 2'd0));
      chk("cpsr", cpsr, m_cpsr);
      chk("retire", retire, m_ret);
      if (m_ret) chk("retire_exec", retire_exec, m_rexec);
      chk("alu_regs", {alu_op, alu_data1[15:0], alu_data2[14:0]}, {m_op, m_d1[15:0], m_d2[14:0]});
      if (m_wbpend) chk("wb_payload", {wb_rd, wb_data}, {m_wb_rd, m_wb_data});
    end
  end

  // Issue one instruction and follow it to retire.
  task automatic run(input logic [3:0] c, input logic [4:0] op, input bit s, input logic [3:0] rd,
                     input logic [31:0] d1, input logic [31:0] d2, input int stall,
                     output bit got_wb, output logic [31:0] wbd, output int first_wb,
                     output bit rexec, output int ret_cyc);
    int k;
    int st;
    st = stall; got_wb = 0; wbd = '0; first_wb = 0; rexec = 0; ret_cyc = 0;
    k = 0;
    while (!in_ready && k < 30) begin @(negedge clk); k++; end
    if (!in_ready) chk("ready_timeout", 0, 1);
    in_valid = 1; in_cond = c; in_op = op; in_s = s; in_rd = rd; in_data1 = d1; in_data2 = d2;
    wb_ready = (stall == 0);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      in_valid = 0;
      if (wb_valid) begin
        if (!got_wb) first_wb = cyc;
        got_wb = 1; wbd = wb_data;
        if (st > 0) begin chk("stall_in_ready", in_ready, 0); chk("stall_wb_data", wbd, {4'h0, d2}); st--; end
        else wb_ready = 1;
      end
      if (retire) begin rexec = retire_exec; ret_cyc = cyc; break; end
    end
    if (ret_cyc == 0) chk("retire_timeout", 0, 1);
  endtask

  bit got_wb, rexec;
  logic [31:0] wbd;
  int first_wb, ret_cyc;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_state", {in_ready, state, wb_valid, retire, retire_exec}, {1'b1, 2'd0, 3'b000});
    chk("rst_regs", {alu_op, alu_data1, alu_data2, cpsr}, 73'd0 >> 0);
    chk("rst_wb", {wb_rd, wb_data}, 36'd0);
    reset = 0;
    @(negedge clk);

    run(4'he, 5'b00100, 1, 4'd2, 32'd3, 32'd7, 0, got_wb, wbd, first_wb, rexec, ret_cyc);
    chk("add_wb", {got_wb, wbd}, {1'b1, 32'd10});
    chk("add_lat", {first_wb[3:0], ret_cyc[3:0]}, {4'd2, 4'd3});
    chk("add_cpsr_rexec", {cpsr, rexec}, {4'b0000, 1'b1});

    run(4'he, 5'b00100, 0, 4'd5, 32'd0, 32'd0, 0, got_wb, wbd, first_wb, rexec, ret_cyc);
    chk("add_s0_cpsr", {got_wb, wbd, cpsr}, {1'b1, 32'd0, 4'b0000});

    run(4'he, 5'b10011, 1, 4'd6, 32'd1, 32'd2, 0, got_wb, wbd, first_wb, rexec, ret_cyc);
    chk("nop", {got_wb, rexec, ret_cyc[3:0], cpsr}, {1'b0, 1'b1, 4'd2, 4'b0000});

    run(4'he, 5'b01010, 0, 4'd0, 32'd5, 32'd5, 0, got_wb, wbd, first_wb, rexec, ret_cyc);
    chk("cmp", {got_wb, rexec, cpsr}, {1'b0, 1'b1, 4'b0011});

    run(4'h0, 5'b00010, 0, 4'd1, 32'd9, 32'd4, 0, got_wb, wbd, first_wb, rexec, ret_cyc);
    chk("sub_eq", {got_wb, wbd, rexec, wb_rd}, {1'b1, 32'd5, 1'b1, 4'd1});

    run(4'h1, 5'b00100, 1, 4'd3, 32'd1, 32'd1, 0, got_wb, wbd, first_wb, rexec, ret_cyc);
    chk("add_ne_squash", {got_wb, rexec, cpsr}, {1'b0, 1'b0, 4'b0011});

    run(4'he, 5'b01101, 0, 4'd4, 32'd0, 32'h0000_00ff, 4, got_wb, wbd, first_wb, rexec, ret_cyc);
    chk("mov_stall", {wbd, rexec, ret_cyc[3:0]}, {32'hff, 1'b1, 4'd7});

    // Reset while holding in WB.
    wb_ready = 0;
    in_valid = 1; in_cond = 4'he; in_op = 5'b01101; in_s = 1; in_rd = 4'd7; in_data2 = 32'h1234;
    @(negedge clk); in_valid = 0;
    repeat (2) @(negedge clk);
    chk("pre_rst_wb", wb_valid, 1);
    #2 reset = 1;
    #1 chk("rst_mid", {wb_valid, state, cpsr, in_ready}, {1'b0, 2'd0, 4'd0, 1'b1});
    @(negedge clk); reset = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); chk("no_retire_after_rst", retire, 0); end

    // Randomised traffic, including garbage while busy.
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom % 3) != 0;
      in_cond  = ($urandom % 3 == 0) ? 4'he : 4'($urandom);
      in_op    = 5'($urandom);
      in_s     = 1'($urandom);
      in_rd    = 4'($urandom);
      in_data1 = ($urandom % 4 == 0) ? $urandom_range(0, 3) : $urandom;
      in_data2 = ($urandom % 4 == 0) ? $urandom_range(0, 3) : $urandom;
      wb_ready = ($urandom % 3) != 0;
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Sequencer that wraps the combinational ALU and runs ARM data-processing instructions one at a time. Accepts a decoded instruction over a valid/ready handshake and evaluates its condition field against an internal CPSR. Drives the ALU, captures its result and flags, updates the CPSR, and issues a register-file writeback over a second valid/ready handshake. Sits between decode and the register file in the execute stage.

## Interface
- DATA_W, 32, operand/result width
- REG_W, 4, destination register index width
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  decoded instruction present
- in_ready  out  1  controller can accept (high only in IDLE)
- in_cond  in  4  ARM condition field
- in_op  in  5  ALU operation code
- in_s  in  1  S bit (set flags)
- in_rd  in  REG_W  destination register
- in_data1, in_data2  in  DATA_W  operands (Rn, shifted operand2)
- alu_op  out  5  registered operation to ALU
- alu_data1, alu_data2  out  DATA_W  registered operands to ALU
- alu_result  in  DATA_W  ALU result (combinational from alu_* outputs)
- alu_flags  in  4  ALU flags {V,N,C,Z} = bits [3:0]
- wb_valid  out  1  writeback request
- wb_ready  in  1  register file accepts writeback
- wb_rd  out  REG_W  writeback register
- wb_data  out  DATA_W  writeback value
- cpsr  out  4  current flags, same bit order as alu_flags
- retire  out  1  one-cycle pulse when an instruction completes
- retire_exec  out  1  valid with retire: 1 = condition passed, 0 = squashed
- state  out  2  debug: 0 IDLE, 1 EXEC, 2 WB

## Operation
- The block has one clock domain. Reset is asynchronous and active-high.
- Op classes:
  - Writeback ops: AND 00000, EOR 00001, SUB 00010, RSB 00011, ADD 00100, ORR 01100, MOV 01101, BIC 01110, MVN 01111.
  - Compare ops: TST 01000, TEQ 01001, CMP 01010, CMN 01011. No writeback; flags always update regardless of in_s.
  - All other codes (00101–00111, 1xxxx): NOP. No writeback, no flag update, retire_exec still reflects the condition.
- Condition on cpsr:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V.
  - GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 never.
- FSM:
  - IDLE: in_ready=1. On in_valid, latch cond/op/s/rd into internal registers and data1/data2/op into the alu_* registers, then go to EXEC.
  - EXEC (always exactly 1 cycle): evaluate the condition on cpsr as it stands at EXEC entry.
    - Fail: go to IDLE, retire=1, retire_exec=0. No cpsr change, no writeback.
    - Pass: cpsr <= alu_flags at the end of EXEC if op is a compare, or if in_s=1 and op is a writeback op.
    - Pass with writeback op: latch wb_data <= alu_result and wb_rd <= rd, then go to WB.
    - Pass otherwise: go to IDLE with retire=1, retire_exec=1.
  - WB: wb_valid=1 with wb_rd/wb_data held stable. On wb_ready, go to IDLE with retire=1, retire_exec=1. Stalls indefinitely while wb_ready=0.
- The alu_* registers hold their last value in IDLE and WB.
- wb_data is stored exactly as the ALU returns it (two's complement, no width change).

## Timing
- Reset values:
  - state=IDLE, in_ready=1.
  - alu_op=0, alu_data1=0, alu_data2=0.
  - wb_valid=0, wb_rd=0, wb_data=0.
  - cpsr=0, retire=0, retire_exec=0.
- Accept at edge k. EXEC occupies cycle k+1. cpsr reflects any update from cycle k+2.
- Writeback op: wb_valid is first high in cycle k+2. Minimum latency is 2 cycles to retire, 3 cycles with writeback.
- Throughput: at most one instruction per 2 cycles, or per 3 cycles with writeback plus any wb_ready stall.
- retire and retire_exec are registered and pulse in the first IDLE cycle after completion. The next accept may occur in that same cycle.
- Back-to-back flag dependency: the second instruction's condition sees the first instruction's updated cpsr.
- in_valid during EXEC/WB is ignored (in_ready=0). The upstream stage holds its instruction.
- wb_ready high outside WB has no effect.
- Reset asserted mid-operation:
  - state goes to IDLE immediately.
  - wb_valid drops asynchronously.
  - The in-flight instruction is discarded with no retire pulse.
  - cpsr is cleared.

## Test plan
- Reset, then ADD AL, S=1, data1=3, data2=7, rd=2 -> wb_valid in cycle k+2 with wb_rd=2, wb_data=10; cpsr=0000; retire_exec=1.
- CMP AL, data1=5, data2=5, S=0 -> no wb_valid; cpsr.Z=1; then SUB EQ, data1=9, data2=4, rd=1 -> wb_data=5 and retire_exec=1.
- After cpsr.Z=1, issue ADD NE, rd=3 -> retire with retire_exec=0, no wb_valid, cpsr unchanged.
- MOV AL, data2=0x0000_00FF, rd=4, with wb_ready held low 4 cycles -> wb_valid held with stable wb_data=0xFF; retire one cycle after wb_ready rises; in_ready=0 throughout.
- ADD AL, S=0, operands giving ALU Z=1 -> cpsr stays 0000. Opcode 10011 with AL -> NOP, retire_exec=1, no wb_valid.
- Assert reset while in WB -> wb_valid=0 in the same cycle, state=IDLE, cpsr=0000, no retire pulse.
